// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side adapter for the synchronous FIFO. It turns the FIFO read
//   interface (rd_en strobe, data returned one cycle later, empty flag) into
//   a valid/ready stream master. Reads are prefetched into a 3-entry circular
//   buffer, so a consumer that holds ready high gets one beat per clock.
//
// Ports
//   clk_i         single clock
//   rst_i         synchronous active-high reset
//   fifo_rd_en_o  read strobe to the FIFO
//   fifo_rdata_i  FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_empty_i  FIFO empty flag
//   m_data_o      stream data (head of buffer, 0 when empty)
//   m_valid_o     stream valid
//   m_ready_i     stream ready from the consumer
//   flush_i       discard all buffered and in-flight data
//   buf_count_o   buffer occupancy, 0..3
//   beats_o       accepted-beat counter, wraps modulo 2^CNT_W
module fifo_rd_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_empty_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  input  logic             flush_i,
  output logic [1:0]       buf_count_o,
  output logic [CNT_W-1:0] beats_o
);

  localparam logic [1:0] LAST_PTR = 2'd2;

  logic [WIDTH-1:0] buf_q [3];
  logic [1:0]       head_q;
  logic [1:0]       tail_q;
  logic [1:0]       count_q;
  logic             inflight_q;
  logic             drop_q;
  logic [CNT_W-1:0] beats_q;

  logic [2:0]       occupancy;
  logic             push;
  logic             pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == LAST_PTR) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Buffered entries plus the one read that may still be returning. Issuing
  // only while this is below 3 guarantees every returning word has a slot,
  // and keeps m_ready_i out of the read-issue path.
  always_comb begin
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  end

  assign fifo_rd_en_o = !rst_i && !flush_i && !fifo_empty_i && (occupancy < 3'd3);

  assign m_valid_o   = (count_q != 2'd0);
  assign m_data_o    = m_valid_o ? buf_q[head_q] : '0;
  assign buf_count_o = count_q;
  assign beats_o     = beats_q;

  // A word returning during a flush cycle is discarded along with the buffer.
  assign push = inflight_q && !drop_q && !flush_i;
  assign pop  = m_valid_o && m_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      beats_q    <= '0;
    end else begin
      inflight_q <= fifo_rd_en_o;
      // Mark the return slot following a flush with a read outstanding, so a
      // late word can never land in the freshly emptied buffer.
      drop_q     <= flush_i && inflight_q;

      if (flush_i) begin
        head_q  <= 2'd0;
        tail_q  <= 2'd0;
        count_q <= 2'd0;
      end else begin
        if (push) begin
          buf_q[tail_q] <= fifo_rdata_i;
          tail_q        <= ptr_inc(tail_q);
        end
        if (pop) begin
          head_q <= ptr_inc(head_q);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 2'd1;
          2'b01:   count_q <= count_q - 2'd1;
          default: count_q <= count_q;
        endcase
      end

      if (pop) begin
        beats_q <= beats_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             m_ready = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic [1:0]       buf_count;
  logic [CNT_W-1:0] beats;
  logic             tb_inflight = 1'b0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] got[$];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_rdata_i (fifo_rdata),
    .fifo_empty_i (fifo_empty),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .flush_i      (flush),
    .buf_count_o  (buf_count),
    .beats_o      (beats)
  );

  // Behavioural synchronous FIFO: registered read data (0 when not reading),
  // registered empty flag.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() != 0) fifo_rdata <= fq.pop_front();
    else fifo_rdata <= '0;
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
    tb_inflight <= fifo_rd_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Continuous invariants and capture of accepted beats.
  always @(negedge clk) begin
    if (!rst) begin
      chk("occupancy", 32'((32'(buf_count) + 32'(tb_inflight)) <= 3), 1);
      if (fifo_empty) chk("rd_when_empty", 32'(fifo_rd_en), 0);
      if (m_valid && m_ready && !flush) got.push_back(m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset while the FIFO is filled with base, base+1, ...; returns in
  // the first cycle with rst deasserted.
  task automatic reset_load(input int n, input logic [WIDTH-1:0] base);
    rst = 1'b1;
    flush = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + WIDTH'(i);
      tick();
    end
    wr_en = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int exp_b;

    // Idle with an empty FIFO.
    reset_load(0, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_rd_en", 32'(fifo_rd_en), 0);
      chk("idle_valid", 32'(m_valid), 0);
      chk("idle_count", 32'(buf_count), 0);
      chk("idle_beats", 32'(beats), 0);
      chk("idle_data", m_data, 0);
      tick();
    end

    // Single word: rd_en pulse, valid two cycles later, one beat.
    m_ready = 1'b1;
    wr_en = 1'b1;
    wr_data = 32'h11;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("single_rd_c1", 32'(fifo_rd_en), 1);
    chk("single_valid_c1", 32'(m_valid), 0);
    tick();
    @(negedge clk);
    chk("single_rd_c2", 32'(fifo_rd_en), 0);
    chk("single_valid_c2", 32'(m_valid), 0);
    tick();
    @(negedge clk);
    chk("single_valid_c3", 32'(m_valid), 1);
    chk("single_data_c3", m_data, 32'h11);
    chk("single_beats_c3", 32'(beats), 0);
    tick();
    @(negedge clk);
    chk("single_valid_c4", 32'(m_valid), 0);
    chk("single_beats_c4", 32'(beats), 1);
    chk("single_data_c4", m_data, 0);

    // Preload 1..8, ready held high: back-to-back delivery.
    reset_load(8, 32'h1);
    m_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("stream_rd_en", 32'(fifo_rd_en), 32'(k <= 7));
      chk("stream_valid", 32'(m_valid), 32'(k >= 2 && k <= 9));
      chk("stream_data", m_data, (k >= 2 && k <= 9) ? 32'(k - 1) : 0);
      exp_b = (k < 2) ? 0 : ((k - 2 > 8) ? 8 : k - 2);
      chk("stream_beats", 32'(beats), 32'(exp_b));
      tick();
    end

    // Preload 1..8, ready low for 10 cycles: exactly 3 reads, head stable.
    reset_load(8, 32'h1);
    got.delete();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_rd_en", 32'(fifo_rd_en), 32'(k <= 2));
      exp_b = (k < 2) ? 0 : ((k == 2) ? 1 : ((k == 3) ? 2 : 3));
      chk("stall_count", 32'(buf_count), 32'(exp_b));
      chk("stall_valid", 32'(m_valid), 32'(k >= 2));
      chk("stall_data", m_data, (k >= 2) ? 32'h1 : 0);
      tick();
    end
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("stall_n_beats", 32'(got.size()), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("stall_order", got[i], 32'(i + 1));
    chk("stall_beats", 32'(beats), 8);

    // Flush with two buffered and one in flight; beats kept at 8.
    flush = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 32'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    got.delete();
    @(negedge clk);
    chk("flush_pre_beats", 32'(beats), 8);
    tick();
    tick();
    tick();
    flush = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("flush_cyc_count", 32'(buf_count), 2);
    chk("flush_cyc_data", m_data, 32'h1);
    chk("flush_cyc_rd_en", 32'(fifo_rd_en), 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_after_valid", 32'(m_valid), 0);
    chk("flush_after_count", 32'(buf_count), 0);
    chk("flush_after_beats", 32'(beats), 8);
    chk("flush_after_rd_en", 32'(fifo_rd_en), 1);
    for (int k = 0; k < 10; k++) tick();
    chk("flush_n_beats", 32'(got.size()), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("flush_order", got[i], 32'(i + 4));
    chk("flush_end_beats", 32'(beats), 13);

    // 17 beats through a 4-bit counter wraps to 1.
    reset_load(17, 32'h100);
    m_ready = 1'b1;
    got.delete();
    @(negedge clk);
    chk("wrap_start_beats", 32'(beats), 0);
    for (int k = 0; k < 25; k++) tick();
    chk("wrap_beats", 32'(beats), 1);
    chk("wrap_n_beats", 32'(got.size()), 17);
    for (int i = 0; i < 17 && i < got.size(); i++) chk("wrap_order", got[i], 32'h100 + 32'(i));

    // Reset mid-stream: buffered 0x202 and in-flight 0x203 are lost.
    reset_load(8, 32'h200);
    m_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_count", 32'(buf_count), 0);
    chk("mid_rst_beats", 32'(beats), 0);
    chk("mid_rst_data", m_data, 0);
    for (int k = 0; k < 15; k++) tick();
    chk("mid_rst_n_beats", 32'(got.size()), 6);
    if (got.size() == 6) begin
      chk("mid_rst_b0", got[0], 32'h200);
      chk("mid_rst_b1", got[1], 32'h201);
      chk("mid_rst_b2", got[2], 32'h204);
      chk("mid_rst_b3", got[3], 32'h205);
      chk("mid_rst_b4", got[4], 32'h206);
      chk("mid_rst_b5", got[5], 32'h207);
    end
    chk("mid_rst_end_beats", 32'(beats), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
